dcache_refill_responder: RTL

- Responder end of the load path's data-cache request interface (dc_req/dc_addr/dc_op/dc_cmo/dc_uncached → dc_data/dc_cmp).
- Services three request kinds: cached-miss line refills into the 2-way data BRAM and tag store, uncached single-beat bus reads, and cache-maintenance (CMO) invalidates.
- Sits between the load queue and the 64-bit system memory bus.

---
 rtl/dcache_pkg.sv | 28 ++
 rtl/dcache_uncached_align.sv | 28 ++
 rtl/dcache_refill_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants and types for the data-cache refill path.
//   - line geometry (LINE_BYTES, BEATS, IDX_W, TAG_W)
//   - load size encodings (size_e)
//   - responder FSM state encoding (state_t + ST_* constants)
package dcache_pkg;

    localparam int LINE_BYTES = 128;
    localparam int BEATS      = 16;    // 64-bit beats per line
    localparam int IDX_W      = 5;     // line index per way, addr[11:7]
    localparam int TAG_W      = 19;    // addr[30:12]

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    // State encoding kept as plain constants so existing waveform decoders
    // and checkers that compare raw 3-bit values keep working.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_ISSUE    = 3'd1;
    localparam state_t ST_BEATS_RX = 3'd2;
    localparam state_t ST_TAGWR    = 3'd3;
    localparam state_t ST_DONE     = 3'd4;
    localparam state_t ST_GAP      = 3'd5;

endpackage

// File: rtl/dcache_uncached_align.sv
// dcache_uncached_align: picks the addressed 32-bit half of a 64-bit bus beat
// and right-justifies the addressed byte/half/word. Upper bits are left
// unmasked; the consumer sign/zero-extends.
//   beat     in  64  bus read beat
//   addr_lo  in   3  request address bits [2:0]
//   op       in   2  access size (size_e)
//   data     out 32  right-justified result
module dcache_uncached_align
    import dcache_pkg::*;
(
    input  logic [63:0] beat,
    input  logic [2:0]  addr_lo,
    input  logic [1:0]  op,
    output logic [31:0] data
);

    logic [31:0] word;

    always_comb begin
        word = addr_lo[2] ? beat[63:32] : beat[31:0];
        case (size_e'(op))
            SZ_BYTE: data = word >> {addr_lo[1:0], 3'b000};
            SZ_HALF: data = word >> {addr_lo[1], 4'b0000};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dcache_refill_responder.sv
// dcache_refill_responder: responder side of the load path's data-cache
// request interface. Services cached-miss line refills (BEATS-beat bursts into
// the 2-way data BRAM, then a tag write), uncached single-beat reads and CMO
// line invalidates.
//
// Handshakes:
//   dc_req is held high by the requester until dc_cmp; dc_cmp is a one-cycle
//   pulse and the requester drops dc_req the cycle after it, which GAP absorbs.
//   mem_req_o is held until mem_gnt_i is seen high on a clock edge; read beats
//   are accepted on every edge where mem_rvalid_i is high (no backpressure).
//
// Ports:
//   core_clock_i / core_reset_i      clock, synchronous active-high reset
//   dc_req/dc_addr/dc_op/dc_cmo/dc_uncached  request from the load queue
//   dc_data/dc_cmp                   uncached data, completion pulse
//   mem_req_o/mem_addr_o/mem_burst_o/mem_gnt_i  bus read request
//   mem_rvalid_i/mem_rdata_i/mem_rlast_i         bus read beats
//   bram_wr_*                        data BRAM refill write {way, idx, beat}
//   tag_wr_*                         tag store write
//   collision_o                      BRAM written this cycle
//   fsm_state                        current FSM state (debug)
module dcache_refill_responder
    import dcache_pkg::*;
#(
    parameter int BEATS = 16,
    parameter int IDX_W = 5
) (
    input  logic                            core_clock_i,
    input  logic                            core_reset_i,
    input  logic                            dc_req,
    input  logic [31:0]                     dc_addr,
    input  logic [1:0]                      dc_op,
    input  logic                            dc_cmo,
    input  logic                            dc_uncached,
    output logic [31:0]                     dc_data,
    output logic                            dc_cmp,
    output logic                            mem_req_o,
    output logic [31:0]                     mem_addr_o,
    output logic                            mem_burst_o,
    input  logic                            mem_gnt_i,
    input  logic                            mem_rvalid_i,
    input  logic [63:0]                     mem_rdata_i,
    input  logic                            mem_rlast_i,
    output logic                            bram_wr_en_o,
    output logic [IDX_W+$clog2(BEATS):0]    bram_wr_addr_o,
    output logic [63:0]                     bram_wr_data_o,
    output logic                            tag_wr_en_o,
    output logic [1:0]                      tag_wr_way_o,
    output logic [IDX_W-1:0]                tag_wr_idx_o,
    output logic [18:0]                     tag_wr_tag_o,
    output logic                            tag_wr_vld_o,
    output logic                            collision_o,
    output state_t                          fsm_state
);

    localparam int BEAT_W = $clog2(BEATS);

    state_t                  state;
    logic [31:0]             addr_q;
    logic [1:0]              op_q;
    logic                    cmo_q;
    logic                    unc_q;
    logic                    victim_q;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [(1<<IDX_W)-1:0]   rr;        // per-index round-robin victim bit
    logic [IDX_W-1:0]        idx_q;
    logic [31:0]             aligned;
    logic                    beat_fire;

    assign idx_q     = addr_q[7+IDX_W-1:7];
    assign beat_fire = (state == ST_BEATS_RX) && mem_rvalid_i;

    dcache_uncached_align u_align (
        .beat    (mem_rdata_i),
        .addr_lo (addr_q[2:0]),
        .op      (op_q),
        .data    (aligned)
    );

    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            state    <= ST_IDLE;
            rr       <= '0;
            dc_data  <= '0;
            addr_q   <= '0;
            op_q     <= '0;
            cmo_q    <= 1'b0;
            unc_q    <= 1'b0;
            victim_q <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dc_req) begin
                        addr_q   <= dc_addr;
                        op_q     <= dc_op;
                        cmo_q    <= dc_cmo;
                        unc_q    <= dc_uncached;
                        // Victim fixed for the whole refill, so every beat
                        // and the tag write land in the same way.
                        victim_q <= rr[dc_addr[7+IDX_W-1:7]];
                        beat_cnt <= '0;
                        state    <= dc_cmo ? ST_TAGWR : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (mem_gnt_i) state <= ST_BEATS_RX;
                end
                ST_BEATS_RX: begin
                    if (mem_rvalid_i) begin
                        if (unc_q) begin
                            dc_data <= aligned;
                            state   <= ST_DONE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                            if (mem_rlast_i) state <= ST_TAGWR;
                        end
                    end
                end
                ST_TAGWR: begin
                    // Tag goes in only after all data beats, so a partial
                    // line is never seen as valid.
                    if (!cmo_q) rr[idx_q] <= ~rr[idx_q];
                    state <= ST_DONE;
                end
                ST_DONE: state <= ST_GAP;
                ST_GAP:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign fsm_state      = state;
    assign dc_cmp         = (state == ST_DONE);

    assign mem_req_o      = (state == ST_ISSUE);
    assign mem_burst_o    = !unc_q;
    assign mem_addr_o     = unc_q ? {addr_q[31:2], 2'b00} : {addr_q[31:7], 7'b0};

    assign bram_wr_en_o   = beat_fire && !unc_q;
    assign collision_o    = beat_fire && !unc_q;
    assign bram_wr_addr_o = {victim_q, idx_q, beat_cnt};
    assign bram_wr_data_o = mem_rdata_i;

    assign tag_wr_en_o    = (state == ST_TAGWR);
    assign tag_wr_way_o   = cmo_q ? 2'b11 : (victim_q ? 2'b10 : 2'b01);
    assign tag_wr_idx_o   = idx_q;
    assign tag_wr_tag_o   = addr_q[30:12];
    assign tag_wr_vld_o   = !cmo_q;

    // A last beat must coincide with the final beat slot of the line.
    rlast_on_final_beat: assert property (@(posedge core_clock_i) disable iff (core_reset_i)
        (beat_fire && !unc_q && mem_rlast_i) |-> (beat_cnt == BEAT_W'(BEATS - 1)));

endmodule
